clk_tick_monitor: RTL and testbench
===================================

# clk_tick_monitor

Receive-side checker for divided tick clocks such as the 1 ms toggle clock produced by the counter divider. It synchronizes a slow toggling input into the `clk` domain and measures the interval between its edges in `clk` cycles. It flags intervals that are too short or too long, and reports lock once the input is stable. It sits beside every divided-clock consumer as a health monitor and drives the status/error counters.

## Interface
Parameters:
- `CNT_W`, 16, width of the interval counter and the `half_period` output.
- `EXP_HALF`, 16'h3334, expected clk cycles between consecutive input edges.
- `TOL`, 4, allowed ± deviation in cycles.
- `LOCK_N`, 4, consecutive in-range measurements required to assert `locked`.
- `SYNC_STAGES`, 2, synchronizer depth, minimum 2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_in`  in  1  slow toggling clock under test; treated as asynchronous.
- `err_clr`  in  1  synchronous clear of `err_cnt`.
- `edge_pulse`  out  1  one-cycle pulse per detected `tick_in` edge (either polarity).
- `meas_valid`  out  1  one-cycle pulse; `half_period` and the error flags are valid in this cycle.
- `half_period`  out  CNT_W  last measured interval in clk cycles.
- `err_fast`  out  1  one-cycle pulse: interval < EXP_HALF−TOL.
- `err_slow`  out  1  one-cycle pulse: interval > EXP_HALF+TOL, or timeout.
- `locked`  out  1  level; input is in range.
- `err_cnt`  out  8  saturating error count.

## Operation
- **Reset values:** every output is 0, the FSM is in IDLE, and all synchronizer flops are 0.
- **Edge detection:** the synchronized `tick_in` is compared with its registered copy; any difference produces `edge_pulse`.
- **Interval counter:** on an edge the counter loads 1, otherwise it increments each cycle. It saturates at all ones.
- **Measurement:** on an edge, interval = current counter value, so edges N cycles apart measure N.
- **IDLE:** the first edge moves to TRACK. No `meas_valid` is produced for this edge.
- **TRACK:** each edge produces `meas_valid` and an in-range check. In range: good_cnt+1; when good_cnt reaches LOCK_N, move to LOCKED and set `locked`=1. Out of range: pulse the error flag and set good_cnt=0.
- **LOCKED:** in range, stay. Out of range, pulse the error flag, set `locked`=0, set good_cnt=0 and move to TRACK.
- **Timeout:** applies in TRACK or LOCKED. When the counter reaches EXP_HALF+TOL+1 with no edge: pulse `err_slow` with no `meas_valid`, set `locked`=0, go to IDLE.
- **Edge and timeout in the same cycle:** the edge path wins. The cycle produces a measurement with `err_slow` set and exactly one error pulse.
- **`err_cnt`:** increments on every `err_fast` or `err_slow` pulse and saturates at 255. `err_clr` clears it. If `err_clr` and an error occur in the same cycle, the result is 1.
- **`half_period`:** holds its value until the next `meas_valid`.

## Timing
- `edge_pulse` asserts on the (SYNC_STAGES+1)th rising `clk` edge, counting the first edge that samples the new `tick_in` level.
- `meas_valid`, `half_period`, `err_fast`/`err_slow` and the `locked` update are all registered in the same cycle as `edge_pulse`.
- A timeout `err_slow` asserts exactly EXP_HALF+TOL+1 cycles after the last `edge_pulse`.
- `err_cnt` updates one cycle after the error pulse.
- Reset mid-operation clears everything immediately. The next edge after reset is treated as a first edge.

## Structure
- **Shared package `clk_mon_pkg`:** FSM state enum (IDLE, TRACK, LOCKED) and default constants (EXP_HALF_1MS = 16'h3334, TOL_DEF = 4, LOCK_N_DEF = 4).
- **Sub-module `sync_edge_det`:** parameterized SYNC_STAGES synchronizer plus edge detector, producing `edge_pulse`.
- **Top level:** counter, compare, FSM and error counter.

## Test plan
All scenarios use EXP_HALF=20, TOL=2, LOCK_N=3 unless stated.
- **Reset:** assert `rst` mid-run → all outputs 0 asynchronously; first edge after release gives no `meas_valid`.
- **Lock acquisition:** toggle every 20 cycles → `meas_valid` with `half_period`=20 from the 2nd edge; `locked`=1 with the 4th edge's `meas_valid`; no errors.
- **Fast interval:** when locked, one interval of 17 → `err_fast` pulse, `half_period`=17, `locked`=0, `err_cnt`=1; relocks after 3 good intervals.
- **Stopped input:** input stops → `err_slow` exactly 23 cycles after the last `edge_pulse`, no `meas_valid`, state IDLE. A later edge gives no measurement.
- **Glitch:** 1-cycle high glitch on a low input → two edges 1 apart → `err_fast` with `half_period`=1.
- **Error counter:** `err_clr` coincident with an error gives `err_cnt`=1; 300 errors saturate `err_cnt` at 255. Default parameters with the 16'h3333-reload divider give `half_period`=16'h3334 and `locked`=1.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the divided-tick clock monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } monState_e;

    localparam logic [15:0] EXP_HALF_1MS = 16'h3334;
    localparam int          TOL_DEF      = 4;
    localparam int          LOCK_N_DEF   = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous level plus a both-polarity edge detector.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o,
    output logic edge_pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prevLevel_q;
    logic                   pulse_q;

    // edge_o is the unregistered detection so the consumer can register its
    // own results in the same cycle that edge_pulse_o rises.
    assign edge_o       = sync_q[SYNC_STAGES-1] ^ prevLevel_q;
    assign edge_pulse_o = pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            prevLevel_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], async_i};
            prevLevel_q <= sync_q[SYNC_STAGES-1];
            pulse_q     <= edge_o;
        end
    end

endmodule

// File: rtl/clk_tick_monitor.sv
// Health monitor for a slow toggling tick clock: measures edge-to-edge intervals,
// flags fast/slow intervals and timeouts, tracks lock and counts errors.
module clk_tick_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int EXP_HALF    = int'(EXP_HALF_1MS),
    parameter int TOL         = TOL_DEF,
    parameter int LOCK_N      = LOCK_N_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             err_clr,
    output logic             edge_pulse,
    output logic             meas_valid,
    output logic [CNT_W-1:0] half_period,
    output logic             err_fast,
    output logic             err_slow,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    localparam int               LO_I        = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
    localparam logic [CNT_W-1:0] LO_LIM      = CNT_W'(LO_I);
    localparam logic [CNT_W-1:0] HI_LIM      = CNT_W'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT     = CNT_W'(EXP_HALF + TOL + 1);
    localparam int               GOOD_W      = $clog2(LOCK_N + 1);
    localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_N);

    monState_e         state_q, state_d;
    logic [CNT_W-1:0]  intervalCnt_q, intervalCnt_d;
    logic [GOOD_W-1:0] goodCnt_q, goodCnt_d;
    logic [GOOD_W-1:0] goodNext;
    logic [CNT_W-1:0]  halfPeriod_q, halfPeriod_d;
    logic              measValid_q, measValid_d;
    logic              errFast_q, errFast_d;
    logic              errSlow_q, errSlow_d;
    logic [7:0]        errCnt_q, errCnt_d;
    logic              edgeDet;
    logic              isFast;
    logic              isSlow;
    logic              errPulse;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .rst          (rst),
        .async_i      (tick_in),
        .edge_o       (edgeDet),
        .edge_pulse_o (edge_pulse)
    );

    assign isFast   = (intervalCnt_q < LO_LIM);
    assign isSlow   = (intervalCnt_q > HI_LIM);
    assign goodNext = goodCnt_q + GOOD_W'(1);
    assign errPulse = errFast_q | errSlow_q;

    always_comb begin
        state_d       = state_q;
        goodCnt_d     = goodCnt_q;
        halfPeriod_d  = halfPeriod_q;
        measValid_d   = 1'b0;
        errFast_d     = 1'b0;
        errSlow_d     = 1'b0;
        intervalCnt_d = intervalCnt_q;
        errCnt_d      = errCnt_q;

        if (edgeDet) begin
            intervalCnt_d = CNT_W'(1);
        end else if (intervalCnt_q != '1) begin
            intervalCnt_d = intervalCnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (edgeDet) begin
                    state_d   = TRACK;
                    goodCnt_d = '0;
                end
            end
            TRACK, LOCKED: begin
                // An edge takes priority over a coincident timeout.
                if (edgeDet) begin
                    measValid_d  = 1'b1;
                    halfPeriod_d = intervalCnt_q;
                    if (isFast || isSlow) begin
                        errFast_d = isFast;
                        errSlow_d = isSlow;
                        goodCnt_d = '0;
                        state_d   = TRACK;
                    end else if (state_q == TRACK) begin
                        goodCnt_d = goodNext;
                        if (goodNext == LOCK_TARGET) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (intervalCnt_q == TIMEOUT) begin
                    errSlow_d = 1'b1;
                    goodCnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_clr) begin
            errCnt_d = {7'd0, errPulse};
        end else if (errPulse && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            intervalCnt_q <= '0;
            goodCnt_q     <= '0;
            halfPeriod_q  <= '0;
            measValid_q   <= 1'b0;
            errFast_q     <= 1'b0;
            errSlow_q     <= 1'b0;
            errCnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            intervalCnt_q <= intervalCnt_d;
            goodCnt_q     <= goodCnt_d;
            halfPeriod_q  <= halfPeriod_d;
            measValid_q   <= measValid_d;
            errFast_q     <= errFast_d;
            errSlow_q     <= errSlow_d;
            errCnt_q      <= errCnt_d;
        end
    end

    assign meas_valid  = measValid_q;
    assign half_period = halfPeriod_q;
    assign err_fast    = errFast_q;
    assign err_slow    = errSlow_q;
    assign locked      = (state_q == LOCKED);
    assign err_cnt     = errCnt_q;

endmodule

// File: tb/tb_clk_tick_monitor.sv
// Directed self-checking bench: small-parameter monitor for the scenarios, plus a
// default-parameter instance fed a 16'h3334-cycle toggle.
module tb_clk_tick_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        errClr = 1'b0;
    logic        edgePulse, measValid, errFast, errSlow, locked;
    logic [15:0] halfPeriod;
    logic [7:0]  errCnt;

    logic        reset2 = 1'b1;
    logic        tick2 = 1'b0;
    logic        edgePulse2, measValid2, errFast2, errSlow2, locked2;
    logic [15:0] halfPeriod2;
    logic [7:0]  errCnt2;
    logic        done2 = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    logic        sEdge, sMeas, sFast, sSlow, sLocked;
    logic [15:0] sHalf;
    logic [7:0]  sErr;

    always #5 clock = ~clock;

    clk_tick_monitor #(
        .CNT_W       (16),
        .EXP_HALF    (20),
        .TOL         (2),
        .LOCK_N      (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clock),
        .rst         (reset),
        .tick_in     (tick),
        .err_clr     (errClr),
        .edge_pulse  (edgePulse),
        .meas_valid  (measValid),
        .half_period (halfPeriod),
        .err_fast    (errFast),
        .err_slow    (errSlow),
        .locked      (locked),
        .err_cnt     (errCnt)
    );

    clk_tick_monitor dut2 (
        .clk         (clock),
        .rst         (reset2),
        .tick_in     (tick2),
        .err_clr     (1'b0),
        .edge_pulse  (edgePulse2),
        .meas_valid  (measValid2),
        .half_period (halfPeriod2),
        .err_fast    (errFast2),
        .err_slow    (errSlow2),
        .locked      (locked2),
        .err_cnt     (errCnt2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Toggle the tick, sample the outputs in the edge_pulse cycle, then idle
    // so the next toggle lands gap cycles after this one.
    task automatic applyStimulus(input int gap);
        tick = ~tick;
        stepCycles(3);
        sEdge   = edgePulse;
        sMeas   = measValid;
        sHalf   = halfPeriod;
        sFast   = errFast;
        sSlow   = errSlow;
        sLocked = locked;
        sErr    = errCnt;
        if (gap > 3) stepCycles(gap - 3);
    endtask

    initial begin
        stepCycles(2);
        reset2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick2 = ~tick2;
            if (k < 4) stepCycles(13108);
        end
        stepCycles(3);
        checkOutput("dfltMeas", measValid2, 1);
        checkOutput("dfltHalf", halfPeriod2, 16'h3334);
        checkOutput("dfltLocked", locked2, 1);
        checkOutput("dfltErr", errCnt2, 0);
        done2 = 1'b1;
    end

    initial begin
        stepCycles(2);
        checkOutput("rstEdge", edgePulse, 0);
        checkOutput("rstMeas", measValid, 0);
        checkOutput("rstHalf", halfPeriod, 0);
        checkOutput("rstFast", errFast, 0);
        checkOutput("rstSlow", errSlow, 0);
        checkOutput("rstLocked", locked, 0);
        checkOutput("rstErrCnt", errCnt, 0);
        reset = 1'b0;
        stepCycles(2);

        applyStimulus(20);
        checkOutput("e1Edge", sEdge, 1);
        checkOutput("e1NoMeas", sMeas, 0);
        applyStimulus(20);
        checkOutput("e2Meas", sMeas, 1);
        checkOutput("e2Half", sHalf, 20);
        checkOutput("e2Locked", sLocked, 0);
        applyStimulus(20);
        checkOutput("e3Locked", sLocked, 0);
        applyStimulus(20);
        checkOutput("e4Meas", sMeas, 1);
        checkOutput("e4Half", sHalf, 20);
        checkOutput("e4Locked", sLocked, 1);
        checkOutput("e4Fast", sFast, 0);
        checkOutput("e4Slow", sSlow, 0);
        checkOutput("e4Err", sErr, 0);
        applyStimulus(17);
        checkOutput("e5Locked", sLocked, 1);
        applyStimulus(20);
        checkOutput("fastMeas", sMeas, 1);
        checkOutput("fastFlag", sFast, 1);
        checkOutput("fastSlow", sSlow, 0);
        checkOutput("fastHalf", sHalf, 17);
        checkOutput("fastLocked", sLocked, 0);
        applyStimulus(20);
        checkOutput("fastErrCnt", sErr, 1);
        checkOutput("relock1", sLocked, 0);
        checkOutput("relock1Fast", sFast, 0);
        applyStimulus(20);
        checkOutput("relock2", sLocked, 0);
        applyStimulus(3);
        checkOutput("relock3", sLocked, 1);
        checkOutput("relock3Meas", sMeas, 1);

        stepCycles(1);
        checkOutput("pulseWidth", edgePulse, 0);
        checkOutput("measWidth", measValid, 0);
        stepCycles(21);
        checkOutput("toEarly", errSlow, 0);
        stepCycles(1);
        checkOutput("toSlow", errSlow, 1);
        checkOutput("toNoMeas", measValid, 0);
        checkOutput("toLocked", locked, 0);
        stepCycles(1);
        checkOutput("toPulseEnd", errSlow, 0);
        checkOutput("toErrCnt", errCnt, 2);

        stepCycles(5);
        applyStimulus(20);
        checkOutput("idleEdge", sEdge, 1);
        checkOutput("idleNoMeas", sMeas, 0);

        tick = 1'b1;
        stepCycles(1);
        tick = 1'b0;
        stepCycles(2);
        checkOutput("glRiseMeas", measValid, 1);
        checkOutput("glRiseHalf", halfPeriod, 20);
        checkOutput("glRiseFast", errFast, 0);
        stepCycles(1);
        checkOutput("glFallMeas", measValid, 1);
        checkOutput("glFallHalf", halfPeriod, 1);
        checkOutput("glFallFast", errFast, 1);
        stepCycles(1);
        checkOutput("glErrCnt", errCnt, 3);

        stepCycles(22);
        checkOutput("clrSlow", errSlow, 1);
        errClr = 1'b1;
        stepCycles(1);
        errClr = 1'b0;
        checkOutput("clrCoinc", errCnt, 1);

        stepCycles(5);
        repeat (310) begin
            tick = ~tick;
            stepCycles(1);
        end
        stepCycles(5);
        checkOutput("errSat", errCnt, 255);
        errClr = 1'b1;
        stepCycles(1);
        errClr = 1'b0;
        checkOutput("errClr", errCnt, 0);

        repeat (5) applyStimulus(20);
        checkOutput("preRstLocked", sLocked, 1);
        #3;
        reset = 1'b1;
        tick = 1'b0;
        #1;
        checkOutput("asyncLocked", locked, 0);
        checkOutput("asyncErrCnt", errCnt, 0);
        checkOutput("asyncHalf", halfPeriod, 0);
        checkOutput("asyncMeas", measValid, 0);
        stepCycles(2);
        reset = 1'b0;
        applyStimulus(20);
        checkOutput("postRstEdge", sEdge, 1);
        checkOutput("postRstNoMeas", sMeas, 0);
        applyStimulus(3);
        checkOutput("postRstMeas", sMeas, 1);
        checkOutput("postRstHalf", sHalf, 20);

        for (int i = 0; i < 60000 && !done2; i++) stepCycles(1);
        checkOutput("dfltDone", done2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
